sfifo_abt_wr_arb: RTL and testbench

SFIFO_ABT_WR_ARB -- requirements
Module: sfifo_abt_wr_arb

---
 rtl/sfifo_abt_wr_arb.sv | 134 +++++++++++++
 tb/tb_sfifo_abt_wr_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_abt_wr_arb.sv
// Two-requester write arbiter in front of an abortable FIFO: round-robin packet
// ownership, commit on last beat, rollback on cancel or write-side stall timeout.
module sfifo_abt_wr_arb #(
    parameter int WIDTH = 8,
    parameter int TMO   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             vld0,
    input  logic             vld1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             last0,
    input  logic             last1,
    input  logic             cancel0,
    input  logic             cancel1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rdy0,
    output logic             rdy1,
    output logic             done0,
    output logic             done1,
    output logic             abt0,
    output logic             abt1,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic             fifo_eot,
    output logic             fifo_abort,
    output logic [WIDTH-1:0] fifo_data
);

    localparam int CW = $clog2(TMO) + 1;
    localparam logic [CW-1:0] STALL_MAX = CW'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_e;

    state_e          state_q;
    logic            sel_q;
    logic            lst_q;
    logic [CW-1:0]   stall_q;
    logic            done0_q;
    logic            done1_q;

    logic            vld_s;
    logic            last_s;
    logic            cancel_s;
    logic            in_xfer;
    logic            owns;
    logic            accept;
    logic            stall;

    assign vld_s    = sel_q ? vld1    : vld0;
    assign last_s   = sel_q ? last1   : last0;
    assign cancel_s = sel_q ? cancel1 : cancel0;
    assign in_xfer  = (state_q == XFER);
    assign owns     = (state_q != IDLE);

    // Cancel wins over a presented beat; a stall is only counted when a beat waits on full.
    assign accept = in_xfer & vld_s & ~fifo_full & ~cancel_s;
    assign stall  = in_xfer & vld_s &  fifo_full & ~cancel_s;

    assign gnt0       = owns & ~sel_q;
    assign gnt1       = owns &  sel_q;
    assign rdy0       = in_xfer & ~sel_q & ~fifo_full;
    assign rdy1       = in_xfer &  sel_q & ~fifo_full;
    assign fifo_wr_en = accept;
    assign fifo_eot   = accept & last_s;
    assign fifo_abort = (state_q == ABORT);
    assign fifo_data  = sel_q ? data1 : data0;
    assign abt0       = fifo_abort & ~sel_q;
    assign abt1       = fifo_abort &  sel_q;
    assign done0      = done0_q;
    assign done1      = done1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            lst_q   <= 1'b1;
            stall_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    stall_q <= '0;
                    if (req0 | req1) begin
                        state_q <= XFER;
                        sel_q   <= (req0 & req1) ? ~lst_q : req1;
                    end
                end
                XFER: begin
                    if (cancel_s) begin
                        state_q <= ABORT;
                        stall_q <= '0;
                    end else if (accept) begin
                        stall_q <= '0;
                        if (last_s) begin
                            state_q <= IDLE;
                            lst_q   <= sel_q;
                            done0_q <= ~sel_q;
                            done1_q <= sel_q;
                        end
                    end else if (stall) begin
                        if (stall_q == STALL_MAX) begin
                            state_q <= ABORT;
                            stall_q <= '0;
                        end else begin
                            stall_q <= stall_q + CW'(1);
                        end
                    end
                end
                ABORT: begin
                    lst_q   <= sel_q;
                    stall_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfifo_abt_wr_arb.sv
// Directed bench for sfifo_abt_wr_arb: arbitration, commit, cancel, timeout,
// full toggling and mid-packet reset, with hand-computed per-cycle expectations.
module tb_sfifo_abt_wr_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, vld0, vld1, last0, last1, cancel0, cancel1, fifo_full;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, rdy0, rdy1, done0, done1, abt0, abt1;
    logic       fifo_wr_en, fifo_eot, fifo_abort;
    logic [7:0] fifo_data;
    logic [10:0] ov;

    int n_tests = 0;
    int n_fail  = 0;

    sfifo_abt_wr_arb #(.WIDTH(8), .TMO(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .vld0(vld0), .vld1(vld1),
        .data0(data0), .data1(data1), .last0(last0), .last1(last1),
        .cancel0(cancel0), .cancel1(cancel1),
        .gnt0(gnt0), .gnt1(gnt1), .rdy0(rdy0), .rdy1(rdy1),
        .done0(done0), .done1(done1), .abt0(abt0), .abt1(abt1),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_eot(fifo_eot),
        .fifo_abort(fifo_abort), .fifo_data(fifo_data)
    );

    always #5 clk = ~clk;

    // {gnt0,gnt1,rdy0,rdy1,done0,done1,abt0,abt1,wr_en,eot,abort}
    assign ov = {gnt0, gnt1, rdy0, rdy1, done0, done1, abt0, abt1,
                 fifo_wr_en, fifo_eot, fifo_abort};

    // {req0,req1,vld0,vld1,last0,last1,cancel0,cancel1,fifo_full}
    task automatic drive(input logic [8:0] s);
        {req0, req1, vld0, vld1, last0, last1, cancel0, cancel1, fifo_full} = s;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(9'b111111110);
        data0 = 8'h5A;
        data1 = 8'hA5;
        tick();
        tick();
        #1;
        n_tests++;
        if (ov !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", ov, 11'b0);
        end
        n_tests++;
        if (fifo_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_fifo_data: got %h want 5a", fifo_data);
        end
        drive(9'b0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_arbitration;
        logic [8:0]  st [11];
        logic [10:0] ex [11];
        st = '{9'b110000000, 9'b111000000, 9'b111000000, 9'b111010000, 9'b110000000,
               9'b110101000, 9'b110000000, 9'b110000000, 9'b001010000, 9'b000000000,
               9'b000000000};
        ex = '{11'b00000000000, 11'b10100000100, 11'b10100000100, 11'b10100000110,
               11'b00001000000, 11'b01010000110, 11'b00000100000, 11'b10100000000,
               11'b10100000110, 11'b00001000000, 11'b00000000000};
        for (int i = 0; i < 11; i++) begin
            drive(st[i]);
            data0 = 8'(16 + i);
            data1 = 8'(128 + i);
            #1;
            n_tests++;
            if (ov !== ex[i]) begin
                n_fail++;
                $display("FAIL arb[%0d]: got %b want %b", i, ov, ex[i]);
            end
            if (ex[i][2]) begin
                n_tests++;
                if (fifo_data !== (ex[i][10] ? 8'(16 + i) : 8'(128 + i))) begin
                    n_fail++;
                    $display("FAIL arb_data[%0d]: got %h", i, fifo_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_cancel;
        logic [8:0]  st [6];
        logic [10:0] ex [6];
        st = '{9'b100000000, 9'b101000000, 9'b101000100, 9'b001000100,
               9'b000000110, 9'b000000000};
        ex = '{11'b00000000000, 11'b10100000100, 11'b10100000000, 11'b10000010001,
               11'b00000000000, 11'b00000000000};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            #1;
            n_tests++;
            if (ov !== ex[i]) begin
                n_fail++;
                $display("FAIL cancel[%0d]: got %b want %b", i, ov, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_timeout;
        int bad = 0;
        drive(9'b010000000);
        tick();
        for (int k = 1; k <= 16; k++) begin
            drive(9'b000100001);
            #1;
            if (ov !== 11'b01000000000) begin
                bad++;
                $display("FAIL timeout_stall[%0d]: got %b want %b", k, ov, 11'b01000000000);
            end
            tick();
        end
        n_tests++;
        if (bad != 0) n_fail++;
        drive(9'b000100001);
        #1;
        n_tests++;
        if (ov !== 11'b01000001001) begin
            n_fail++;
            $display("FAIL timeout_abort: got %b want %b", ov, 11'b01000001001);
        end
        tick();
        drive(9'b0);
        #1;
        n_tests++;
        if (ov !== 11'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: got %b want %b", ov, 11'b0);
        end
        tick();
    endtask

    task automatic test_full_toggle;
        int bad = 0;
        drive(9'b100000000);
        tick();
        for (int k = 0; k < 14; k++) begin
            drive(9'b001000001);
            #1;
            if (ov !== 11'b10000000000) begin
                bad++;
                $display("FAIL toggle_stall_a[%0d]: got %b", k, ov);
            end
            tick();
        end
        drive(9'b001000000);
        #1;
        if (ov !== 11'b10100000100) begin
            bad++;
            $display("FAIL toggle_accept: got %b want %b", ov, 11'b10100000100);
        end
        tick();
        for (int k = 0; k < 15; k++) begin
            drive(9'b001000001);
            #1;
            if (ov !== 11'b10000000000) begin
                bad++;
                $display("FAIL toggle_stall_b[%0d]: got %b", k, ov);
            end
            tick();
        end
        n_tests++;
        if (bad != 0) n_fail++;
        drive(9'b001010000);
        #1;
        n_tests++;
        if (ov !== 11'b10100000110) begin
            n_fail++;
            $display("FAIL toggle_last: got %b want %b", ov, 11'b10100000110);
        end
        tick();
        drive(9'b0);
        #1;
        n_tests++;
        if (ov !== 11'b00001000000) begin
            n_fail++;
            $display("FAIL toggle_done: got %b want %b", ov, 11'b00001000000);
        end
        tick();
    endtask

    task automatic test_reset_mid_packet;
        drive(9'b110000000);
        tick();
        drive(9'b110100000);
        data0 = 8'h3C;
        data1 = 8'hC3;
        #1;
        n_tests++;
        if (ov !== 11'b01010000100) begin
            n_fail++;
            $display("FAIL midrst_owner1: got %b want %b", ov, 11'b01010000100);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ov !== 11'b0 || fifo_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b/%h want 0/3c", ov, fifo_data);
        end
        tick();
        rst_n = 1'b1;
        drive(9'b110000000);
        tick();
        drive(9'b111010000);
        #1;
        n_tests++;
        if (ov !== 11'b10100000110) begin
            n_fail++;
            $display("FAIL midrst_regrant0: got %b want %b", ov, 11'b10100000110);
        end
        tick();
        drive(9'b0);
        #1;
        n_tests++;
        if (ov !== 11'b00001000000) begin
            n_fail++;
            $display("FAIL midrst_done0: got %b want %b", ov, 11'b00001000000);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        data0 = '0;
        data1 = '0;
        drive(9'b0);
        test_reset();
        test_arbitration();
        test_cancel();
        test_timeout();
        test_full_toggle();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
